// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header: removes a per-packet N-byte header and realigns the payload to lane 0
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    input  logic                    ready_hdr,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
);
    localparam int CW = BYTE_CNT_WD + 1;
    localparam logic [CW-1:0] NB = CW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {S_HEAD, S_BODY, S_FLUSH} state_t;

    state_t state, state_nxt;
    logic [DATA_WD-1:0] res_data;
    logic [CW-1:0] res_cnt;
    logic out_free, hdr_free, fire, flush_fire, head, emit;
    logic [CW-1:0] strip_n, c, src_cnt, pre_cnt, t, pay_cnt, r_nxt;
    logic [DATA_WD-1:0] data_m, src, pre;
    logic [2*DATA_WD-1:0] wide;

    function automatic logic [DATA_BYTE_WD-1:0] kmask(input logic [CW-1:0] k);
        kmask = ~({DATA_BYTE_WD{1'b1}} >> k);
    endfunction

    function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] k);
        lane_mask = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) lane_mask[i*8 +: 8] = {8{k[i]}};
    endfunction

    // Byte merge: residue bytes followed by this beat's bytes (header already removed on a packet start)
    always_comb begin
        strip_n = byte_strip_cnt > NB ? NB : byte_strip_cnt;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(keep_in[i]);
        data_m = data_in & lane_mask(keep_in);
        head = state == S_HEAD;
        src_cnt = head ? (c > strip_n ? c - strip_n : '0) : c;
        src = head ? data_m << {strip_n, 3'b000} : data_m;
        pre_cnt = head ? '0 : res_cnt;
        pre = head ? '0 : res_data;
        t = pre_cnt + src_cnt;
        wide = {pre, {DATA_WD{1'b0}}} | ({src, {DATA_WD{1'b0}}} >> {pre_cnt, 3'b000});
        emit = ~head | t == NB | (last_in & t != '0);
        pay_cnt = t > NB ? NB : t;
        r_nxt = emit ? (t > NB ? t - NB : '0) : t;
    end

    // Handshake and next-state decode
    always_comb begin
        out_free = ~valid_out | ready_out;
        hdr_free = ~valid_hdr | ready_hdr;
        ready_in = ~rst & (state == S_HEAD ? out_free & hdr_free : state == S_BODY ? out_free : 1'b0);
        fire = valid_in & ready_in;
        flush_fire = state == S_FLUSH & out_free;
        state_nxt = fire ? (last_in ? (t > NB ? S_FLUSH : S_HEAD) : S_BODY) : flush_fire ? S_HEAD : state;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_HEAD;
        else state <= state_nxt;
    end

    // Residue bytes carried into the next beat; lanes beyond res_cnt are kept zero
    always_ff @(posedge clk) begin
        if (rst || flush_fire) begin
            res_data <= '0;
            res_cnt <= '0;
        end else if (fire) begin
            res_data <= emit ? wide[DATA_WD-1:0] : wide[2*DATA_WD-1:DATA_WD];
            res_cnt <= r_nxt;
        end
    end

    // Payload output register, held until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out <= '0;
            keep_out <= '0;
            last_out <= 1'b0;
        end else if (fire && emit) begin
            valid_out <= 1'b1;
            data_out <= wide[2*DATA_WD-1:DATA_WD];
            keep_out <= kmask(pay_cnt);
            last_out <= last_in & t <= NB;
        end else if (flush_fire) begin
            valid_out <= 1'b1;
            data_out <= res_data;
            keep_out <= kmask(res_cnt);
            last_out <= 1'b1;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

    // Header output register, loaded from the first beat of a packet when N is non-zero
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_hdr <= 1'b0;
            data_hdr <= '0;
            keep_hdr <= '0;
        end else if (fire && head && strip_n != '0) begin
            valid_hdr <= 1'b1;
            data_hdr <= data_m & lane_mask(kmask(strip_n));
            keep_hdr <= keep_in & kmask(strip_n);
        end else if (ready_hdr) begin
            valid_hdr <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// tb_axi_stream_strip_header: scoreboard bench for the header strip block
module tb_axi_stream_strip_header;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_in = 1'b0, last_in = 1'b0, ready_in;
    logic [31:0] data_in = '0;
    logic [3:0] keep_in = '0;
    logic [2:0] byte_strip_cnt = '0;
    logic valid_hdr, valid_out, last_out;
    logic ready_hdr = 1'b1, ready_out = 1'b1;
    logic [31:0] data_hdr, data_out;
    logic [3:0] keep_hdr, keep_out;

    typedef struct {logic [31:0] d; logic [3:0] k; logic l;} beat_t;
    beat_t exp_out[$];
    beat_t exp_hdr[$];
    beat_t eo, eh;
    int checks = 0, errors = 0;
    logic done;
    logic [7:0] pkt[$];
    logic [31:0] bd;
    logic [3:0] bk;

    axi_stream_strip_header dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
        .byte_strip_cnt(byte_strip_cnt),
        .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-level reference: header = first min(N,C0) bytes, payload = bytes from N on, re-chunked
    task automatic model_pkt(input logic [7:0] b[$], input int n);
        int nc, c0, h, p;
        beat_t e;
        nc = n > 4 ? 4 : n;
        c0 = b.size() > 4 ? 4 : b.size();
        h = nc < c0 ? nc : c0;
        if (n > 0) begin
            e.d = '0; e.k = '0; e.l = 1'b0;
            for (int j = 0; j < h; j++) begin
                e.d[31-8*j -: 8] = b[j];
                e.k[3-j] = 1'b1;
            end
            exp_hdr.push_back(e);
        end
        p = nc;
        while (p < b.size()) begin
            e.d = '0; e.k = '0;
            for (int j = 0; j < 4 && p < b.size(); j++) begin
                e.d[31-8*j -: 8] = b[p];
                e.k[3-j] = 1'b1;
                p++;
            end
            e.l = p >= b.size();
            exp_out.push_back(e);
        end
    endtask

    task automatic beat_fill(input logic [7:0] b[$], input int i, output logic [31:0] d, output logic [3:0] k);
        for (int j = 0; j < 4; j++) begin
            if (4*i + j < b.size()) begin
                d[31-8*j -: 8] = b[4*i+j];
                k[3-j] = 1'b1;
            end else begin
                d[31-8*j -: 8] = 8'hEE;
                k[3-j] = 1'b0;
            end
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input int n);
        int w = 0;
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l; byte_strip_cnt = 3'(n);
        @(negedge clk);
        while (!ready_in && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!ready_in) chk("in_timeout", 32'(ready_in), 32'd1);
        @(posedge clk);
        #1 valid_in = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b[$], input int n);
        int nb;
        logic [31:0] d;
        logic [3:0] k;
        nb = (b.size() + 3) / 4;
        model_pkt(b, n);
        for (int i = 0; i < nb; i++) begin
            beat_fill(b, i, d, k);
            send_beat(d, k, i == nb - 1, n);
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_out.size() != 0 || exp_hdr.size() != 0) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_out", 32'(exp_out.size()), 32'd0);
        chk("drain_hdr", 32'(exp_hdr.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitors: a transfer is seen at the negedge before the capturing posedge
    always @(negedge clk) begin
        if (!rst && valid_out && ready_out) begin
            if (exp_out.size() == 0) chk("out_extra", 32'(exp_out.size()), 32'd1);
            else begin
                eo = exp_out.pop_front();
                chk("out_data", data_out, eo.d);
                chk("out_keep", 32'(keep_out), 32'(eo.k));
                chk("out_last", 32'(last_out), 32'(eo.l));
            end
        end
        if (!rst && valid_hdr && ready_hdr) begin
            if (exp_hdr.size() == 0) chk("hdr_extra", 32'(exp_hdr.size()), 32'd1);
            else begin
                eh = exp_hdr.pop_front();
                chk("hdr_data", data_hdr, eh.d);
                chk("hdr_keep", 32'(keep_hdr), 32'(eh.k));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_valid_hdr", 32'(valid_hdr), 32'd0);
        chk("rst_last_out", 32'(last_out), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_keep_out", 32'(keep_out), 32'd0);
        chk("rst_data_hdr", data_hdr, 32'd0);
        chk("rst_keep_hdr", 32'(keep_hdr), 32'd0);
        chk("rst_ready_in", 32'(ready_in), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_pkt(pkt, 1);
        drain();
        pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        send_pkt(pkt, 3);
        drain();

        pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        model_pkt(pkt, 0);
        for (int i = 0; i < 3; i++) begin
            beat_fill(pkt, i, bd, bk);
            send_beat(bd, bk, i == 2, 0);
            if (i == 0) begin
                chk("lat_valid", 32'(valid_out), 32'd1);
                chk("lat_data", data_out, 32'h01020304);
            end
        end
        drain();

        pkt = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_pkt(pkt, 4);
        send_pkt(pkt, 7);
        pkt = '{8'h5A, 8'hA5};
        send_pkt(pkt, 3);
        drain();

        pkt = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D};
        fork
            send_pkt(pkt, 1);
            begin
                logic [31:0] hd;
                logic [3:0] hk;
                repeat (2) @(posedge clk);
                #1 ready_out = 1'b0;
                @(negedge clk);
                hd = data_out;
                hk = keep_out;
                repeat (5) begin
                    chk("stall_valid", 32'(valid_out), 32'd1);
                    chk("stall_data", data_out, hd);
                    chk("stall_keep", 32'(keep_out), 32'(hk));
                    chk("stall_ready_in", 32'(ready_in), 32'd0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 ready_out = 1'b1;
            end
        join
        drain();

        ready_hdr = 1'b0;
        pkt = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        send_pkt(pkt, 2);
        pkt = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        fork
            send_pkt(pkt, 1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("hdr_block", 32'(ready_in), 32'd0);
                end
                @(posedge clk);
                #1 ready_hdr = 1'b1;
            end
        join
        drain();

        pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        model_pkt(pkt, 1);
        beat_fill(pkt, 0, bd, bk);
        send_beat(bd, bk, 1'b0, 1);
        beat_fill(pkt, 1, bd, bk);
        send_beat(bd, bk, 1'b0, 1);
        for (int w = 0; valid_out && w < 20; w++) @(negedge clk);
        @(posedge clk);
        #1 ready_out = 1'b0;
        beat_fill(pkt, 2, bd, bk);
        send_beat(bd, bk, 1'b1, 1);
        chk("flush_pending", 32'(valid_out), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid_out", 32'(valid_out), 32'd0);
        chk("rst_mid_valid_hdr", 32'(valid_hdr), 32'd0);
        chk("rst_mid_dropped", 32'(exp_out.size()), 32'd2);
        exp_out.delete();
        exp_hdr.delete();
        @(posedge clk);
        #1 ready_out = 1'b1;
        pkt = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
        send_pkt(pkt, 2);
        drain();

        done = 1'b0;
        fork
            begin
                logic [7:0] rp[$];
                int len;
                for (int p = 0; p < 20; p++) begin
                    rp.delete();
                    len = $urandom_range(1, 13);
                    for (int j = 0; j < len; j++) rp.push_back(8'($urandom));
                    send_pkt(rp, $urandom_range(0, 5));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ready_out = $urandom_range(0, 3) != 0;
                    ready_hdr = $urandom_range(0, 3) != 0;
                end
                ready_out = 1'b1;
                ready_hdr = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
